// File: rtl/izh_fixed_pkg.sv
// Q-format fixed-point helpers and synapse FSM encoding shared by the synapse slice.
// Pure package: no latency, no flow control.
package izh_fixed_pkg;

    localparam int N = 24;
    localparam int Q = 8;

    typedef logic signed [N-1:0] word_t;

    localparam word_t ONE   = word_t'(1 << Q);
    localparam word_t MAX_S = {1'b0, {(N-1){1'b1}}};
    localparam word_t MIN_S = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECAY   = 2'd1,
        ACCUM   = 2'd2,
        CURRENT = 2'd3
    } syn_state_t;

    // One guard bit catches overflow: the top two bits disagree only on wrap.
    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1]) begin
            return s[N] ? MIN_S : MAX_S;
        end
        return word_t'(s[N-1:0]);
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        logic [N:0] s;
        s = {a[N-1], a} - {b[N-1], b};
        if (s[N] != s[N-1]) begin
            return s[N] ? MIN_S : MAX_S;
        end
        return word_t'(s[N-1:0]);
    endfunction

    function automatic word_t clamp(input word_t x, input word_t lo, input word_t hi);
        if (x < lo) begin
            return lo;
        end
        if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/izhikevich_synapse_fixed_mul.sv
// Combinational signed Q-format multiply: full product, arithmetic shift by Q, saturate to N bits.
// Zero latency; no flow control.
module fixed_mul #(
    parameter int N = 24,
    parameter int Q = 8
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] p
);

    logic signed [2*N-1:0] a_x;
    logic signed [2*N-1:0] b_x;
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] shr;
    logic                  fits;

    assign a_x  = {{N{a[N-1]}}, a};
    assign b_x  = {{N{b[N-1]}}, b};
    assign prod = a_x * b_x;
    assign shr  = prod >>> Q;

    // The shifted value fits when everything above bit N-1 is a copy of the sign.
    assign fits = (shr[2*N-1:N-1] == {(N+1){shr[N-1]}});

    always_comb begin
        p = shr[N-1:0];
        if (!fits) begin
            p = shr[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

endmodule

// File: rtl/izhikevich_synapse.sv
// Conductance synapse: decay g, add weight on a presynaptic spike, drive i_syn = g*(e_rev - v_post).
// Step accepted only in IDLE; results and a one-cycle done land 3 edges later; steps while busy are dropped.
module izhikevich_synapse #(
    parameter int N  = 24,
    parameter int Q  = 8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step,
    input  logic                 pre_spike,
    input  logic signed [N-1:0]  v_post,
    input  logic signed [N-1:0]  weight,
    input  logic signed [N-1:0]  decay,
    input  logic signed [N-1:0]  e_rev,
    input  logic signed [N-1:0]  g_max,
    output logic                 busy,
    output logic                 done,
    output logic signed [N-1:0]  g,
    output logic signed [N-1:0]  i_syn,
    output logic [CW-1:0]        spike_count
);

    import izh_fixed_pkg::*;

    syn_state_t          state_q;
    logic                spike_q;
    logic signed [N-1:0] vsnap_q;
    logic signed [N-1:0] gt_q;
    logic signed [N-1:0] gt_d;
    logic signed [N-1:0] g_q;
    logic signed [N-1:0] isyn_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                busy_q;
    logic                done_q;

    logic signed [N-1:0] mul_a;
    logic signed [N-1:0] mul_b;
    logic signed [N-1:0] mul_p;

    // Single multiplier: decay product in DECAY, current product in CURRENT.
    always_comb begin
        mul_a = g_q;
        mul_b = clamp(decay, '0, ONE);
        if (state_q == CURRENT) begin
            mul_a = gt_q;
            mul_b = sat_sub(e_rev, vsnap_q);
        end
    end

    fixed_mul #(
        .N (N),
        .Q (Q)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        gt_d  = gt_q;
        cnt_d = cnt_q;
        case (state_q)
            DECAY: begin
                gt_d = sat_sub(g_q, mul_p);
            end
            ACCUM: begin
                gt_d = clamp(spike_q ? sat_add(gt_q, weight) : gt_q, '0, g_max);
                if (spike_q && (cnt_q != {CW{1'b1}})) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                gt_d  = gt_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            spike_q <= 1'b0;
            vsnap_q <= '0;
            gt_q    <= '0;
            g_q     <= '0;
            isyn_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            gt_q   <= gt_d;
            cnt_q  <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (step) begin
                        spike_q <= pre_spike;
                        vsnap_q <= v_post;
                        busy_q  <= 1'b1;
                        state_q <= DECAY;
                    end
                end
                DECAY: begin
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    state_q <= CURRENT;
                end
                CURRENT: begin
                    isyn_q  <= mul_p;
                    g_q     <= gt_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign g           = g_q;
    assign i_syn       = isyn_q;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_izhikevich_synapse.sv
// Self-checking bench: directed literal cases plus randomized steps against a step-level reference model.
module tb_izhikevich_synapse;

    localparam int N  = 24;
    localparam int CW = 16;
    localparam longint SMAX = 64'sd8388607;
    localparam longint SMIN = -64'sd8388608;

    logic                clk = 1'b0;
    logic                rst;
    logic                step;
    logic                pre_spike;
    logic signed [N-1:0] v_post;
    logic signed [N-1:0] weight;
    logic signed [N-1:0] decay;
    logic signed [N-1:0] e_rev;
    logic signed [N-1:0] g_max;
    logic                busy;
    logic                done;
    logic signed [N-1:0] g;
    logic signed [N-1:0] i_syn;
    logic [CW-1:0]       spike_count;

    always #5 clk = ~clk;

    izhikevich_synapse #(.N(24), .Q(8), .CW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .pre_spike   (pre_spike),
        .v_post      (v_post),
        .weight      (weight),
        .decay       (decay),
        .e_rev       (e_rev),
        .g_max       (g_max),
        .busy        (busy),
        .done        (done),
        .g           (g),
        .i_syn       (i_syn),
        .spike_count (spike_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    function automatic longint mulq(input longint a, input longint b);
        longint p;
        p = (a * b) >>> 8;
        return sat(p);
    endfunction

    // Reference model: an accepted step finishes 3 edges later; the count moves one edge before.
    longint m_g, m_i, m_v;
    int     m_cnt, left;
    bit     m_busy, m_done, m_spk;

    always @(posedge clk) begin : model
        longint gt, d;
        if (rst) begin
            m_g = 0; m_i = 0; m_cnt = 0; m_busy = 0; m_done = 0;
            left = 0; m_spk = 0; m_v = 0;
        end else begin
            m_done = 0;
            if (left == 0) begin
                if (step) begin
                    m_spk = pre_spike; m_v = v_post; left = 3; m_busy = 1;
                end
            end else begin
                left--;
                if (left == 1 && m_spk && m_cnt < 65535) m_cnt++;
                if (left == 0) begin
                    gt = sat(m_g - mulq(m_g, decay));
                    if (m_spk) gt = sat(gt + weight);
                    if (gt < 0) gt = 0;
                    if (gt > g_max) gt = g_max;
                    d = sat(longint'(e_rev) - m_v);
                    m_i = mulq(gt, d);
                    m_g = gt;
                    m_done = 1; m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_g", g, m_g);
            check("cyc_i_syn", i_syn, m_i);
            check("cyc_spike_count", spike_count, m_cnt);
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
        end
    end

    // Drives one step (held for 'hold' cycles), watches a fixed window for done.
    task automatic run_step(input bit spk, input longint v, input int hold,
                            output int lat, output int ndone);
        @(negedge clk);
        step = 1'b1; pre_spike = spk; v_post = v[N-1:0];
        lat = -1; ndone = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k >= hold) step = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1; step = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    int lat, nd, cnt_before;
    longint v65;

    initial begin
        v65 = -16640;
        rst = 1'b1; step = 1'b0; pre_spike = 1'b0; v_post = '0;
        weight = 24'sd256; decay = 24'sd64; g_max = 24'sd1024; e_rev = '0;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        check("reset_g", g, 0);
        check("reset_i_syn", i_syn, 0);
        check("reset_count", spike_count, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        run_step(1'b1, v65, 1, lat, nd);
        check("spike_latency", lat, 4);
        check("spike_ndone", nd, 1);
        check("spike_g", g, 256);
        check("spike_i_syn", i_syn, 16640);
        check("spike_count", spike_count, 1);
        run_step(1'b0, v65, 1, lat, nd);
        check("decay1_g", g, 192);
        check("decay1_i_syn", i_syn, 12480);
        run_step(1'b0, v65, 1, lat, nd);
        check("decay2_g", g, 144);
        check("decay2_i_syn", i_syn, 9360);

        pulse_reset();
        g_max = 24'sd384;
        run_step(1'b1, v65, 1, lat, nd);
        check("clamp1_g", g, 256);
        run_step(1'b1, v65, 1, lat, nd);
        check("clamp2_g", g, 384);

        cnt_before = int'(spike_count);
        run_step(1'b1, v65, 2, lat, nd);
        check("busy_ndone", nd, 1);
        check("busy_count", spike_count, cnt_before + 1);

        @(negedge clk); step = 1'b1; pre_spike = 1'b1; v_post = v65[N-1:0];
        @(negedge clk); step = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_accum_g", g, 0);
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("rst_accum_ndone", nd, 0);
        check("rst_accum_g_after", g, 0);

        g_max = 24'h7FFFFF; weight = 24'h7FFFFF; e_rev = 24'h7FFFFF; decay = 24'sd64;
        run_step(1'b1, -64'sd8388608, 1, lat, nd);
        check("sat_i_syn", i_syn, SMAX);
        check("sat_g", g, SMAX);

        for (int c = 0; c < 4000; c++) begin
            int r;
            logic [31:0] u;
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1; step = 1'b0;
            end else begin
                rst = 1'b0;
                if (left == 0 && $urandom_range(0, 3) == 0) begin
                    decay = N'($urandom_range(0, 256));
                    u = $urandom;
                    weight = ($urandom_range(0, 7) == 0) ? {1'b0, u[22:0]} : N'($urandom_range(0, 3000));
                    u = $urandom;
                    g_max = ($urandom_range(0, 7) == 0) ? {1'b0, u[22:0]} : N'($urandom_range(0, 6000));
                    r = int'($urandom_range(0, 40000)) - 20000;
                    e_rev = r[N-1:0];
                end
                step = ($urandom_range(0, 2) == 0);
                pre_spike = $urandom_range(0, 1) == 1;
                u = $urandom;
                r = int'($urandom_range(0, 40000)) - 20000;
                v_post = ($urandom_range(0, 9) == 0) ? u[N-1:0] : r[N-1:0];
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
